ralu_sequencer: RTL and testbench

RALU_SEQUENCER -- requirements
Module: ralu_sequencer

---
 rtl/ralu_sequencer.sv | 153 +++++++++++++++
 tb/tb_ralu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ralu_sequencer.sv
// Microcode sequencer that drives an external RALU datapath and GPR file.
// Decodes LDI/ALU/SHF/OUT words into per-cycle register, shift and write controls.
module ralu_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        busy,
  output logic [3:0]  S,
  output logic        M,
  output logic        Pin,
  output logic        A,
  output logic [3:0]  DataIn,
  output logic        wr,
  output logic [2:0]  adr,
  output logic [3:0]  v,
  output logic        ISL,
  output logic        ISR,
  input  logic        OSL,
  input  logic        OSR,
  input  logic        Pout,
  input  logic [3:0]  R,
  output logic        carry,
  output logic [3:0]  result,
  output logic        result_valid
);

  typedef enum logic [2:0] {IDLE, LDA, LDB, SHIFT, EXEC, OUT} state_t;
  typedef enum logic [1:0] {OP_LDI, OP_ALU, OP_SHF, OP_OUT} op_t;

  state_t      state, state_nx;
  logic [15:0] iw;
  logic [2:0]  cnt;
  logic        c_q;
  op_t         op;
  logic        dir;
  logic        fill_bit;

  assign op          = op_t'(iw[15:14]);
  assign dir         = iw[7];
  assign fill_bit    = iw[3] & c_q;
  assign instr_ready = (state == IDLE);
  assign busy        = !instr_ready;
  assign carry       = c_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    S        = '0;
    M        = 1'b0;
    Pin      = 1'b0;
    A        = 1'b0;
    DataIn   = '0;
    wr       = 1'b0;
    adr      = '0;
    v        = '0;
    ISL      = 1'b0;
    ISR      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) state_nx = (instr[15:14] == 2'b10) ? LDB : LDA;
      end
      LDA: begin
        v = 4'b0001;
        if (op == OP_LDI) begin
          A      = 1'b1;
          DataIn = iw[3:0];
        end else begin
          adr = iw[10:8];
        end
        case (op)
          OP_ALU:  state_nx = LDB;
          OP_OUT:  state_nx = OUT;
          default: state_nx = EXEC;
        endcase
      end
      LDB: begin
        v   = 4'b0110;
        adr = (op == OP_ALU) ? iw[7:5] : iw[10:8];
        state_nx = (op == OP_SHF && cnt != 3'd0) ? SHIFT : EXEC;
      end
      SHIFT: begin
        v   = dir ? 4'b0100 : 4'b0010;
        ISL = !dir & fill_bit;
        ISR = dir & fill_bit;
        if (cnt <= 3'd1) state_nx = EXEC;
      end
      EXEC: begin
        wr  = 1'b1;
        adr = iw[13:11];
        case (op)
          OP_ALU: begin
            S   = iw[4:1];
            M   = iw[0];
            Pin = c_q;
          end
          OP_SHF: begin
            S = 4'b1010;
            M = 1'b1;
          end
          default: begin
            S = 4'b1111;
            M = 1'b1;
          end
        endcase
        state_nx = IDLE;
      end
      OUT: begin
        S        = 4'b1111;
        M        = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter is loaded on every accept; only SHF words ever consume it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iw           <= '0;
      cnt          <= '0;
      c_q          <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == IDLE && instr_valid) begin
        iw  <= instr;
        cnt <= instr[6:4];
      end else if (state == SHIFT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (state == EXEC) begin
        case (op)
          OP_LDI: if (iw[4]) c_q <= iw[5];
          OP_ALU: c_q <= Pout;
          OP_SHF: if (iw[6:4] != 3'd0) c_q <= dir ? OSR : OSL;
          default: ;
        endcase
      end
      if (state == OUT) begin
        result       <= R;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ralu_sequencer.sv
// Bench for ralu_sequencer: behavioural RALU/GPR environment plus an
// instruction-level reference model (register file, carry, OUT result).
module tb_ralu_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready, busy, M, Pin, A, wr, ISL, ISR, OSL, OSR, Pout;
  logic        carry, result_valid;
  logic [3:0]  S, DataIn, v, R, result;
  logic [2:0]  adr;

  always #5 clock = ~clock;

  ralu_sequencer dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .S(S), .M(M), .Pin(Pin), .A(A),
    .DataIn(DataIn), .wr(wr), .adr(adr), .v(v), .ISL(ISL), .ISR(ISR),
    .OSL(OSL), .OSR(OSR), .Pout(Pout), .R(R), .carry(carry),
    .result(result), .result_valid(result_valid)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [4:0] alu_f(input logic [3:0] s, input logic m,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
    logic [4:0] t;
    if (m) begin
      case (s)
        4'hF:    t = {1'b0, a};
        4'hA:    t = {1'b0, b};
        4'hB:    t = {1'b0, a & b};
        4'hE:    t = {1'b0, a | b};
        4'h6:    t = {1'b0, a ^ b};
        4'h0:    t = {1'b0, ~a};
        default: t = 5'h00;
      endcase
    end else begin
      case (s)
        4'h9:    t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        4'h6:    t = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
        default: t = {1'b0, a} + {4'b0, cin};
      endcase
    end
    return t;
  endfunction

  // RALU + GPR environment reacting to the sequencer's controls
  logic [3:0] gpr [8];
  logic [3:0] rega, regb;
  logic       oslr = 1'b0, osrr = 1'b0;
  logic       gpr_clr;
  int         nwr = 0;
  int         v3_bad = 0;
  logic [4:0] alu_o;

  assign alu_o = alu_f(S, M, rega, regb, Pin);
  assign R     = alu_o[3:0];
  assign Pout  = alu_o[4];
  assign OSL   = oslr;
  assign OSR   = osrr;

  always @(posedge clock) begin
    if (gpr_clr) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 4'h0;
    end else if (wr) begin
      gpr[adr] <= R;
      nwr      <= nwr + 1;
    end
    if (v[0]) rega <= A ? DataIn : gpr[adr];
    case (v[2:1])
      2'b11: regb <= gpr[adr];
      2'b01: begin regb <= {regb[2:0], ISL}; oslr <= regb[3]; end
      2'b10: begin regb <= {ISR, regb[3:1]}; osrr <= regb[0]; end
      default: ;
    endcase
    if (v[3]) v3_bad <= v3_bad + 1;
  end

  // Instruction-level reference state
  logic [3:0] rg [8];
  logic       rc;
  logic [3:0] rres;

  logic [20:0] cur;
  logic [20:0] tr [32];
  assign cur = {v, wr, adr, S, M, A, DataIn, ISL, ISR, Pin};

  function automatic logic [20:0] pk(input logic [3:0] vv, input logic w, input logic [2:0] a,
                                     input logic [3:0] s, input logic m, input logic aa,
                                     input logic [3:0] d, input logic il, input logic ir,
                                     input logic p);
    return {vv, w, a, s, m, aa, d, il, ir, p};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [2:0] d, input logic [3:0] im,
                                         input logic setc, input logic cval);
    return {2'b00, d, 5'b0, cval, setc, im};
  endfunction
  function automatic logic [15:0] mk_alu(input logic [2:0] d, input logic [2:0] sa,
                                         input logic [2:0] sb, input logic [3:0] s, input logic m);
    return {2'b01, d, sa, sb, s, m};
  endfunction
  function automatic logic [15:0] mk_shf(input logic [2:0] d, input logic [2:0] src,
                                         input logic dr, input logic [2:0] c, input logic fl);
    return {2'b10, d, src, dr, c, fl, 3'b000};
  endfunction
  function automatic logic [15:0] mk_out(input logic [2:0] src);
    return {2'b11, 3'b000, src, 8'h00};
  endfunction

  function automatic logic [31:0] env_pack();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = gpr[i];
    return p;
  endfunction
  function automatic logic [31:0] ref_pack();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = rg[i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_exec(input logic [15:0] w, output int lat, output int nw);
    logic [3:0] x;
    logic [4:0] t;
    logic       co, f;
    int         n;
    case (w[15:14])
      2'b00: begin
        rg[w[13:11]] = w[3:0];
        if (w[4]) rc = w[5];
        lat = 2; nw = 1;
      end
      2'b01: begin
        t = alu_f(w[4:1], w[0], rg[w[10:8]], rg[w[7:5]], rc);
        rg[w[13:11]] = t[3:0];
        rc  = t[4];
        lat = 3; nw = 1;
      end
      2'b10: begin
        x  = rg[w[10:8]];
        n  = int'(w[6:4]);
        f  = w[3] & rc;
        co = rc;
        for (int i = 0; i < n; i++) begin
          if (w[7]) begin co = x[0]; x = {f, x[3:1]}; end
          else      begin co = x[3]; x = {x[2:0], f}; end
        end
        rg[w[13:11]] = x;
        rc  = co;
        lat = 2 + n; nw = 1;
      end
      default: begin
        rres = rg[w[10:8]];
        lat = 2; nw = 0;
      end
    endcase
  endtask

  task automatic start(input logic [15:0] w);
    chk("ready_before", {30'b0, instr_ready, busy}, 32'h2);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clock);
  endtask

  // Called just after the accepting edge; traces busy cycles and checks outcome.
  task automatic complete(input logic [15:0] w, input logic hold, input logic [15:0] junk,
                          input string tag);
    int  elat, enw, lat, w0;
    bit  done;
    ref_exec(w, elat, enw);
    w0 = nwr; lat = 0; done = 0;
    for (int k = 0; k < 24 && !done; k++) begin
      @(negedge clock);
      if (k == 0) begin
        if (hold) instr = junk;
        else      instr_valid = 1'b0;
      end
      if (instr_ready) done = 1;
      else begin tr[lat] = cur; lat++; end
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_nwr"}, nwr - w0, enw);
    chk({tag, "_carry"}, {31'b0, carry}, {31'b0, rc});
    chk({tag, "_rvalid"}, {31'b0, result_valid}, {31'b0, w[15:14] == 2'b11});
    chk({tag, "_result"}, {28'b0, result}, {28'b0, rres});
    chk({tag, "_gprs"}, env_pack(), ref_pack());
    if (enw == 1 && lat > 0) chk({tag, "_wrlast"}, {31'b0, tr[lat-1][16]}, 32'h1);
  endtask

  task automatic run(input logic [15:0] w, input string tag);
    start(w);
    complete(w, 1'b0, 16'h0000, tag);
  endtask

  logic [4:0]  smt [8] = '{5'h12, 5'h0C, 5'h1F, 5'h15, 5'h17, 5'h1D, 5'h0D, 5'h01};
  logic [31:0] r;
  logic [15:0] w;
  int          w0;

  initial begin
    instr = '0; instr_valid = 1'b0; gpr_clr = 1'b1;
    for (int i = 0; i < 8; i++) rg[i] = 4'h0;
    rc = 1'b0; rres = 4'h0;
    repeat (2) @(negedge clock);
    chk("rst_ctrl", {11'b0, cur}, 32'h0);
    chk("rst_status", {27'b0, instr_ready, busy, carry, result_valid, 1'b0},
        {27'b0, 5'b10000});
    chk("rst_result", {28'b0, result}, 32'h0);
    gpr_clr = 1'b0;
    reset_n = 1'b1;

    // LDI with carry set
    run(mk_ldi(3'd5, 4'h9, 1'b1, 1'b1), "ldi");
    chk("ldi_c1", {11'b0, tr[0]}, {11'b0, pk(4'b0001, 0, 3'd0, 4'h0, 0, 1, 4'h9, 0, 0, 0)});
    chk("ldi_c2", {11'b0, tr[1]}, {11'b0, pk(4'b0000, 1, 3'd5, 4'hF, 1, 0, 4'h0, 0, 0, 0)});
    chk("ldi_gpr5", {28'b0, gpr[5]}, 32'h9);

    // ALU add 3 + 5 with C cleared
    run(mk_ldi(3'd1, 4'h3, 1'b1, 1'b0), "ldi1");
    run(mk_ldi(3'd2, 4'h5, 1'b0, 1'b0), "ldi2");
    run(mk_alu(3'd3, 3'd1, 3'd2, 4'h9, 1'b0), "alu");
    chk("alu_c1", {11'b0, tr[0]}, {11'b0, pk(4'b0001, 0, 3'd1, 4'h0, 0, 0, 4'h0, 0, 0, 0)});
    chk("alu_c2", {11'b0, tr[1]}, {11'b0, pk(4'b0110, 0, 3'd2, 4'h0, 0, 0, 4'h0, 0, 0, 0)});
    chk("alu_c3", {11'b0, tr[2]}, {11'b0, pk(4'b0000, 1, 3'd3, 4'h9, 0, 0, 4'h0, 0, 0, 0)});
    chk("alu_gpr3", {28'b0, gpr[3]}, 32'h8);

    // Shift left 1011 by 3, zero fill
    run(mk_ldi(3'd4, 4'hB, 1'b0, 1'b0), "ldi4");
    run(mk_shf(3'd7, 3'd4, 1'b0, 3'd3, 1'b0), "shfl");
    chk("shfl_c1", {11'b0, tr[0]}, {11'b0, pk(4'b0110, 0, 3'd4, 4'h0, 0, 0, 4'h0, 0, 0, 0)});
    for (int i = 1; i <= 3; i++)
      chk("shfl_shift", {11'b0, tr[i]}, {11'b0, pk(4'b0010, 0, 3'd0, 4'h0, 0, 0, 4'h0, 0, 0, 0)});
    chk("shfl_exec", {11'b0, tr[4]}, {11'b0, pk(4'b0000, 1, 3'd7, 4'hA, 1, 0, 4'h0, 0, 0, 0)});
    chk("shfl_gpr7", {28'b0, gpr[7]}, 32'h8);
    chk("shfl_carry", {31'b0, carry}, 32'h1);

    // Zero-count shift is a plain copy, carry kept
    run(mk_shf(3'd0, 3'd4, 1'b1, 3'd0, 1'b1), "shf0");
    chk("shf0_exec", {11'b0, tr[1]}, {11'b0, pk(4'b0000, 1, 3'd0, 4'hA, 1, 0, 4'h0, 0, 0, 0)});
    chk("shf0_gpr0", {28'b0, gpr[0]}, 32'hB);
    chk("shf0_carry", {31'b0, carry}, 32'h1);

    // Right shift filling with C
    run(mk_shf(3'd2, 3'd4, 1'b1, 3'd2, 1'b1), "shfr");
    chk("shfr_isr", {11'b0, tr[1]}, {11'b0, pk(4'b0100, 0, 3'd0, 4'h0, 0, 0, 4'h0, 0, 1, 0)});

    // OUT with valid held throughout; a different word held while busy
    run(mk_ldi(3'd6, 4'h6, 1'b0, 1'b0), "ldi6");
    start(mk_out(3'd6));
    complete(mk_out(3'd6), 1'b1, mk_ldi(3'd7, 4'hF, 1'b1, 1'b0), "out");
    chk("out_result", {28'b0, result}, 32'h6);
    w = mk_ldi(3'd1, 4'hC, 1'b0, 1'b0);
    instr = w;
    @(posedge clock);
    complete(w, 1'b0, 16'h0000, "b2b");

    // Reset during the second SHIFT cycle
    run(mk_ldi(3'd3, 4'hD, 1'b1, 1'b1), "ldi3");
    start(mk_shf(3'd5, 3'd3, 1'b0, 3'd5, 1'b1));
    repeat (3) @(negedge clock);
    chk("rst_mid_busy", {31'b0, busy}, 32'h1);
    w0 = nwr;
    #2 reset_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("rst_mid_ctrl", {11'b0, cur}, 32'h0);
    chk("rst_mid_status", {28'b0, instr_ready, carry, result_valid, 1'b0}, {28'b0, 4'b1000});
    chk("rst_mid_result", {28'b0, result}, 32'h0);
    rc = 1'b0; rres = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_mid_nowr", nwr - w0, 32'h0);
    reset_n = 1'b1;
    w = mk_ldi(3'd5, 4'h3, 1'b0, 1'b0);
    instr = w; instr_valid = 1'b1;
    @(posedge clock);
    complete(w, 1'b0, 16'h0000, "post_rst");

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      case (r[31:30])
        2'b00:   w = mk_ldi(r[2:0], r[6:3], r[7], r[8]);
        2'b01:   w = mk_alu(r[2:0], r[5:3], r[8:6], smt[r[11:9]][4:1], smt[r[11:9]][0]);
        2'b10:   w = mk_shf(r[2:0], r[5:3], r[6], r[9:7], r[10]);
        default: w = mk_out(r[2:0]);
      endcase
      run(w, "rnd");
    end

    chk("v3_zero", v3_bad, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
